// File: rtl/vga_pkg.sv
// Shared raster geometry, framebuffer sizing and pixel types for the VGA pixel path.
package vga_pkg;

  localparam logic [9:0] H_START  = 10'd144;
  localparam logic [9:0] V_START  = 10'd31;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] H_END    = H_START + H_ACTIVE;
  localparam logic [9:0] V_END    = V_START + V_ACTIVE;

  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int ADDR_W      = 15;
  localparam int ITER_W      = 8;

  localparam logic [ITER_W-1:0] MAX_ITER = 8'd255;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Per-pixel control tag that travels alongside the framebuffer read.
  typedef struct packed {
    logic valid;
    logic active;
    logic hs;
    logic vs;
  } pix_tag_t;

endpackage

// File: rtl/iter_to_rgb332.sv
// Combinational palette: Mandelbrot iteration count to RGB332, black inside the set.
module iter_to_rgb332
  import vga_pkg::*;
(
  input  logic [ITER_W-1:0] iter_i,
  output rgb332_t           rgb_o
);

  always_comb begin
    rgb_o = '0;
    if (iter_i != MAX_ITER) begin
      rgb_o.r = iter_i[2:0];
      rgb_o.g = iter_i[5:3];
      rgb_o.b = iter_i[7:6];
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Raster position -> framebuffer read -> RGB332, with syncs delayed to match and
// front/back bank swapping on the vsync falling edge.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              fb_rd_en,
  output logic [ADDR_W:0]   fb_rd_addr,
  input  logic [ITER_W-1:0] fb_rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_bank,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hsync,
  output logic              vsync
);

  logic [9:0]        hcount_q;
  logic              primed_q,  primed_d;
  logic              vs_q;
  logic              rd_en_q,   rd_en_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic              bank_q,    bank_d;
  logic              ack_q,     ack_d;
  rgb332_t           rgb_q,     rgb_d;
  logic              hs_q,      hs_d;
  logic              vs_out_q,  vs_out_d;
  pix_tag_t          pipe_q [RAM_LATENCY+1];
  pix_tag_t          pipe_d [RAM_LATENCY+1];

  logic              pix_stb;
  logic              active;
  logic [9:0]        h_off, v_off;
  logic [14:0]       y_ext, lin_addr;
  rgb332_t           pal_rgb;

  iter_to_rgb332 u_palette (
    .iter_i (fb_rd_data),
    .rgb_o  (pal_rgb)
  );

  // primed_q masks the first clk after reset so a stale hcount_q cannot fake a strobe.
  assign pix_stb = primed_q && (hcount != hcount_q);
  assign active  = (hcount >= H_START) && (hcount < H_END) &&
                   (vcount >= V_START) && (vcount < V_END);

  // y*160 as (y<<7)+(y<<5); only meaningful inside the active window.
  assign h_off    = (hcount - H_START) >> SCALE_SHIFT;
  assign v_off    = (vcount - V_START) >> SCALE_SHIFT;
  assign y_ext    = 15'(v_off);
  assign lin_addr = (y_ext << 7) + (y_ext << 5) + 15'(h_off);

  // NOTE: every signal gets a default before any branch, so no latch can be inferred.
  always_comb begin
    primed_d  = 1'b1;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    bank_d    = bank_q;
    ack_d     = 1'b0;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_out_d  = vs_out_q;

    pipe_d[0] = '{valid: pix_stb, active: active, hs: hsync_in, vs: vsync_in};
    for (int k = 1; k <= RAM_LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end

    if (pix_stb && active) begin
      rd_en_d   = 1'b1;
      rd_addr_d = {bank_q, lin_addr};
    end

    if (pipe_q[RAM_LATENCY].valid) begin
      hs_d     = pipe_q[RAM_LATENCY].hs;
      vs_out_d = pipe_q[RAM_LATENCY].vs;
      rgb_d    = pipe_q[RAM_LATENCY].active ? pal_rgb : '0;
    end

    // A request still high at a later edge toggles again; upstream owns dropping it.
    if (vs_q && !vsync_in && swap_req) begin
      bank_d = ~bank_q;
      ack_d  = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q  <= '0;
      primed_q  <= 1'b0;
      vs_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      bank_q    <= 1'b0;
      ack_q     <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_out_q  <= 1'b1;
      // NOTE: the tag pipe is a few flops, not a RAM, so it is reset to drop in-flight pixels.
      pipe_q    <= '{default: '0};
    end else begin
      hcount_q  <= hcount;
      primed_q  <= primed_d;
      vs_q      <= vsync_in;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      bank_q    <= bank_d;
      ack_q     <= ack_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_out_q  <= vs_out_d;
      pipe_q    <= pipe_d;
    end
  end

  assign fb_rd_en   = rd_en_q;
  assign fb_rd_addr = rd_addr_q;
  assign swap_ack   = ack_q;
  assign front_bank = bank_q;
  assign red        = rgb_q.r;
  assign green      = rgb_q.g;
  assign blue       = rgb_q.b;
  assign hsync      = hs_q;
  assign vsync      = vs_out_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: directed corners plus random raster positions
// against a arithmetic reference model of address, colour, sync delay and bank swapping.
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        fb_rd_en;
  logic [15:0] fb_rd_addr;
  logic [7:0]  fb_rd_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        front_bank;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic        hsync;
  logic        vsync;

  int          n_total = 0;
  int          n_bad   = 0;

  int          ram_mode = 0;     // 0: hashed contents, 1: always 0x2D, 2: always 255
  logic        force_2d = 1'b0;  // drive 0x2D on the data bus regardless of reads
  logic        exp_bank;
  logic        prev_vs;
  logic [9:0]  exp_out;          // {r,g,b,hs,vs}
  logic [15:0] exp_addr;
  logic [9:0]  last_h;

  localparam logic [9:0] RESET_OUT = 10'b000_000_00_1_1;

  vga_pixel_fetch #(.RAM_LATENCY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .front_bank (front_bank),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync      (hsync),
    .vsync      (vsync)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input logic [15:0] a);
    logic [15:0] t;
    if (ram_mode == 1) return 8'h2D;
    if (ram_mode == 2) return 8'hFF;
    t = a * 16'd40503;
    return t[15:8] ^ a[7:0];
  endfunction

  // Single-cycle-latency framebuffer model.
  always @(posedge clk) begin
    if (force_2d)      fb_rd_data <= 8'h2D;
    else if (fb_rd_en) fb_rd_data <= ram_val(fb_rd_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {red, green, blue, hsync, vsync};
  endfunction

  // Present one raster position and check read, swap and output timing around it.
  task automatic drive_pixel(input logic [9:0] h, input logic [9:0] v,
                             input logic hs, input logic vs, input logic sr);
    logic       act;
    logic       swp;
    int         lin;
    logic [15:0] ea;
    logic [7:0] d;
    logic [9:0] eo;
    @(posedge clk); #1;
    hcount   = h;
    vcount   = v;
    hsync_in = hs;
    vsync_in = vs;
    swap_req = sr;
    last_h   = h;

    act = (h >= 144) && (h < 784) && (v >= 31) && (v < 511);
    swp = prev_vs && !vs && sr;
    prev_vs = vs;
    lin = ((int'(v) - 31) / 4) * 160 + (int'(h) - 144) / 4;
    ea  = {exp_bank, lin[14:0]};
    if (act) exp_addr = ea;
    if (swp) exp_bank = ~exp_bank;
    d  = force_2d ? 8'h2D : ram_val(ea);
    if (!act || d == 8'hFF) eo = {8'h00, hs, vs};
    else                    eo = {d[2:0], d[5:3], d[7:6], hs, vs};

    @(posedge clk); #1;
    check("rd_en", fb_rd_en, act);
    check("rd_addr", fb_rd_addr, exp_addr);
    check("swap_ack", swap_ack, swp);
    check("front_bank", front_bank, exp_bank);
    @(posedge clk); #1;
    check("rd_en_pulse", fb_rd_en, 1'b0);
    check("swap_ack_pulse", swap_ack, 1'b0);
    check("out_hold", outs(), exp_out);
    @(posedge clk); #1;
    check("pixel_out", outs(), eo);
    exp_out = eo;
  endtask

  initial begin
    logic [9:0] h, v;

    // Reset with random inputs on every port.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      hcount   = 10'($urandom_range(0, 799));
      vcount   = 10'($urandom_range(0, 524));
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      swap_req = 1'($urandom);
      check("rst_outs", outs(), RESET_OUT);
      check("rst_rd_en", fb_rd_en, 1'b0);
      check("rst_bank", front_bank, 1'b0);
      check("rst_ack", swap_ack, 1'b0);
    end
    hcount = 10'd300; vcount = 10'd100;
    hsync_in = 1'b1; vsync_in = 1'b1; swap_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_bank = 1'b0; prev_vs = 1'b1; exp_out = RESET_OUT; exp_addr = '0; last_h = 10'd300;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_rd_before_change", fb_rd_en, 1'b0);
    end

    // Address corners.
    drive_pixel(10'd144, 10'd31, 1'b1, 1'b1, 1'b0);
    check("addr_first", fb_rd_addr, 16'd0);
    drive_pixel(10'd783, 10'd510, 1'b1, 1'b1, 1'b0);
    check("addr_last", fb_rd_addr, 16'd19199);
    drive_pixel(10'd147, 10'd31, 1'b1, 1'b1, 1'b0);
    drive_pixel(10'd148, 10'd31, 1'b1, 1'b1, 1'b0);
    check("addr_x1", fb_rd_addr, 16'd1);

    // Colour mapping and inside-set black.
    ram_mode = 1;
    drive_pixel(10'd300, 10'd200, 1'b1, 1'b1, 1'b0);
    check("red_2d", red, 3'd5);
    check("green_2d", green, 3'd5);
    check("blue_2d", blue, 2'd0);
    ram_mode = 2;
    drive_pixel(10'd301, 10'd200, 1'b1, 1'b1, 1'b0);
    check("inside_black", {red, green, blue}, 8'd0);
    ram_mode = 0;

    // Blanking with live data on the bus, hsync low.
    force_2d = 1'b1;
    drive_pixel(10'd100, 10'd200, 1'b0, 1'b1, 1'b0);
    check("blank_rgb", {red, green, blue}, 8'd0);
    check("blank_hsync", hsync, 1'b0);
    force_2d = 1'b0;

    // Swap requested across a vsync fall, then a fall with no request.
    drive_pixel(10'd200, 10'd5, 1'b1, 1'b1, 1'b1);
    drive_pixel(10'd201, 10'd0, 1'b1, 1'b0, 1'b1);
    drive_pixel(10'd202, 10'd1, 1'b1, 1'b0, 1'b0);
    drive_pixel(10'd203, 10'd2, 1'b1, 1'b1, 1'b0);
    check("bank_after_swap", front_bank, 1'b1);
    drive_pixel(10'd400, 10'd40, 1'b1, 1'b1, 1'b0);
    check("addr_bank1", fb_rd_addr[15], 1'b1);
    drive_pixel(10'd204, 10'd3, 1'b1, 1'b0, 1'b0);
    drive_pixel(10'd205, 10'd4, 1'b1, 1'b1, 1'b0);
    check("bank_no_req", front_bank, 1'b1);

    // Random raster positions, syncs and swap requests.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        h = 10'($urandom_range(144, 783));
        v = 10'($urandom_range(31, 510));
      end else begin
        h = 10'($urandom_range(0, 799));
        v = 10'($urandom_range(0, 524));
      end
      if (h == last_h) h = (h == 10'd799) ? 10'd0 : h + 10'd1;
      drive_pixel(h, v, 1'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom));
    end

    // Reset while a read is in flight.
    drive_pixel(10'd399, 10'd100, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    hcount = 10'd400; vcount = 10'd100; hsync_in = 1'b0; vsync_in = 1'b1; swap_req = 1'b0;
    @(posedge clk); #1;
    check("inflight_rd_en", fb_rd_en, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_outs", outs(), RESET_OUT);
    check("midrst_rd_en", fb_rd_en, 1'b0);
    check("midrst_addr", fb_rd_addr, 16'd0);
    check("midrst_bank", front_bank, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_bank = 1'b0; prev_vs = 1'b1; exp_out = RESET_OUT; exp_addr = '0; last_h = 10'd400;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", fb_rd_en, 1'b0);
      check("post_rst_outs", outs(), RESET_OUT);
    end
    drive_pixel(10'd404, 10'd100, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
Pixel stage directly downstream of the VGA timing driver. It takes the driver's hcount/vcount/hsync/vsync, turns the visible raster position into a read address for a double-buffered Mandelbrot iteration framebuffer, and maps each returned iteration count to RGB332. It delays the syncs so they line up with the colour, and it swaps framebuffer banks during vertical sync when the upstream iteration engine requests it.

Parameters:
H_START, 144, first visible hcount (96 sync + 48 back porch)
V_START, 31, first visible vcount (2 sync + 29 back porch)
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SCALE_SHIFT, 2, log2 upscale factor; framebuffer is (H_ACTIVE>>SCALE_SHIFT) x (V_ACTIVE>>SCALE_SHIFT) = 160x120
ADDR_W, 15, per-bank framebuffer address width (19200 entries)
ITER_W, 8, iteration count width
MAX_ITER, 255, iteration value meaning "inside set"
RAM_LATENCY, 1, clocks from fb_rd_en to valid fb_rd_data (1..3)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
hcount  in  10  horizontal position from timing driver, changes once per 4 clk
vcount  in  10  vertical position from timing driver
hsync_in  in  1  active-low hsync from timing driver
vsync_in  in  1  active-low vsync from timing driver
fb_rd_en  out  1  framebuffer read strobe, one clk wide
fb_rd_addr  out  ADDR_W+1  {bank, y*160+x}
fb_rd_data  in  ITER_W  iteration count, RAM_LATENCY clk after fb_rd_en
swap_req  in  1  level; upstream engine has finished writing the back bank
swap_ack  out  1  one-clk pulse when the bank swap takes effect
front_bank  out  1  bank currently displayed; upstream writes ~front_bank
red  out  3  pixel red
green  out  3  pixel green
blue  out  2  pixel blue
hsync  out  1  delayed hsync, aligned with RGB
vsync  out  1  delayed vsync, aligned with RGB

Behaviour:
- Reset values (async): fb_rd_en=0, fb_rd_addr=0, swap_ack=0, front_bank=0, red/green/blue=0, hsync=1, vsync=1. Pipeline valid flags clear. Reset mid-line discards the pixel in flight. First output follows the first hcount change after rst drops.
- Pixel strobe: hcount is registered every clk. pix_stb=1 for one clk when hcount differs from its registered copy. hcount must remain stable for at least RAM_LATENCY+2 clk.
- Stage A (clk after pix_stb): capture active=(H_START<=h<H_START+H_ACTIVE)&&(V_START<=v<V_START+V_ACTIVE), hsync_in, vsync_in. x=(h-H_START)>>SCALE_SHIFT, y=(v-V_START)>>SCALE_SHIFT. y*160 computed as (y<<7)+(y<<5), with no multiplier. If active: fb_rd_en=1 and fb_rd_addr={front_bank, y*160+x}. If not active: fb_rd_en=0 and fb_rd_addr holds its value.
- Stage B (RAM_LATENCY clk after stage A): register the outputs together. hsync/vsync take the captured values.
  - If active and fb_rd_data==MAX_ITER: RGB=0.
  - If active and fb_rd_data!=MAX_ITER: red=d[2:0], green=d[5:3], blue=d[7:6].
  - If blank: RGB=0.
- Latency: outputs update exactly RAM_LATENCY+2 clk after hcount changes, then hold until the next update.
- Swap: a vsync_in falling edge is detected on registered vsync_in.
  - Edge with swap_req=1: front_bank toggles and swap_ack=1 for one clk, both on the same clk.
  - Edge with swap_req=0: no change.
  - swap_req rising on the same clk as the edge: the request is taken.
  - After swap_ack, upstream must drop swap_req before the next edge. If it is still high at the next edge, the bank toggles again (documented, not guarded).
  - Since the swap happens in vsync, no visible pixel ever reads a mixed bank.
- Boundaries: x wraps only within the active window. h=H_START+H_ACTIVE-1 gives x=159, and v=V_START+V_ACTIVE-1 gives y=119, so the last address is 19199. The hcount wrap 799->0 is treated as an ordinary change.

Decomposition:
- Shared package vga_pkg: H_START, V_START, H_ACTIVE, V_ACTIVE, FB_W=160, FB_H=120, ITER_W, MAX_ITER, and a typedef for the rgb332 struct {r[2:0], g[2:0], b[1:0]}.
- One sub-module, iter_to_rgb332: a combinational palette map that can later be swapped for a LUT.
- Address and sync pipeline stay in the top module.

Test Plan:
- Reset: hold rst with random inputs -> RGB=0, hsync=vsync=1, front_bank=0, fb_rd_en=0. Release -> no fb_rd_en until hcount changes.
- Address corners: hcount=144,vcount=31 -> fb_rd_addr=0. hcount=783,vcount=510 -> 19199. hcount=147->148 on line 31 -> x goes from 0 to 1.
- Colour: RAM model returns 0x2D when active -> red=5, green=5, blue=0, exactly 3 clk after the hcount change (RAM_LATENCY=1). Returns 255 -> RGB=0.
- Blanking: hcount=100 with fb_rd_data forced to 0x2D -> RGB=0, no fb_rd_en, and hsync follows hsync_in 3 clk later.
- Swap: swap_req=1 before vsync_in falls -> swap_ack pulses once, front_bank=1, and the next frame's addresses have bit15=1. swap_req=0 at the edge -> no toggle.
- Reset mid-line: assert rst at hcount=400 with a read in flight -> outputs return to reset values immediately. After release, the first RGB appears 3 clk after the next hcount change.
